vga_sync: RTL and testbench

- Display-timing generator that drives the pixel_x/pixel_y/video_on interface consumed by the graphic generator.
- Also drives the board-level hsync/vsync pins.
- Divides the system clock down to a pixel tick and runs horizontal/vertical counters for 640x480@60 Hz.
- Sits between the top-level clock/reset and every pixel-rendering block.

---
 rtl/vga_timing_pkg.sv | 44 ++++
 rtl/vga_sync_pixel_tick_gen.sv | 41 ++++
 rtl/vga_sync.sv | 116 +++++++++++
 tb/tb_vga_sync.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared 640x480@60 Hz display-timing constants. The graphic generator and
// sprite blocks import this for screen bounds; vga_sync uses the defaults as
// its parameter values.
//   COORD_W        : width of pixel_x / pixel_y coordinates
//   *_DEF          : default porch / sync / visible sizes
//   *_TOTAL_DEF    : pixels per line, lines per frame
//   *_SYNC_START/END_DEF : sync window, start inclusive, end exclusive
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int COORD_W = 10;

  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL_DEF = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  localparam int H_SYNC_START_DEF = H_DISPLAY_DEF + H_FRONT_DEF;
  localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
  localparam int V_SYNC_START_DEF = V_DISPLAY_DEF + V_FRONT_DEF;
  localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

  typedef logic [COORD_W-1:0] coord_t;

  // Pin level for a sync signal given whether its window is active.
  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

  // lo <= v < hi
  function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_sync_pixel_tick_gen.sv
// ---------------------------------------------------------------------------
// pixel_tick_gen
// Divides clk down to a one-clk pixel-enable pulse every CLK_DIV clocks.
//   clk    : system clock
//   rst    : asynchronous, active-low reset
//   p_tick : registered pulse, high for the clk after the divider hits
//            CLK_DIV-1 (held high permanently when CLK_DIV = 1)
// CLK_DIV legal range 1..16.
// ---------------------------------------------------------------------------
module pixel_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic p_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_reg, div_next;
  logic             tick_reg, tick_next;

  always_comb begin
    tick_next = (div_reg == DIV_LAST);
    div_next  = tick_next ? '0 : div_reg + DIV_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_reg  <= '0;
      tick_reg <= 1'b0;
    end else begin
      div_reg  <= div_next;
      tick_reg <= tick_next;
    end
  end

  assign p_tick = tick_reg;

endmodule

// File: rtl/vga_sync.sv
// ---------------------------------------------------------------------------
// vga_sync
// Display-timing generator: pixel tick, horizontal/vertical counters and
// registered hsync/vsync/video_on decodes.
//   clk         : system clock
//   rst         : asynchronous, active-low reset
//   p_tick      : one-clk pixel enable, every CLK_DIV clocks
//   pixel_x     : horizontal count 0..H_TOTAL-1
//   pixel_y     : vertical count 0..V_TOTAL-1
//   video_on    : inside the visible area
//   hsync/vsync : sync pins, active level SYNC_POL
//   frame_start : one-clk pulse when the counters wrap to (0,0)
// ---------------------------------------------------------------------------
module vga_sync
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_DISPLAY = V_DISPLAY_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF,
  parameter int CLK_DIV   = 4,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic   clk,
  input  logic   rst,
  output logic   p_tick,
  output coord_t pixel_x,
  output coord_t pixel_y,
  output logic   video_on,
  output logic   hsync,
  output logic   vsync,
  output logic   frame_start
);

  localparam coord_t H_LAST    = coord_t'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam coord_t V_LAST    = coord_t'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
  localparam coord_t H_VIS     = coord_t'(H_DISPLAY);
  localparam coord_t V_VIS     = coord_t'(V_DISPLAY);
  localparam coord_t H_SYNC_LO = coord_t'(H_DISPLAY + H_FRONT);
  localparam coord_t H_SYNC_HI = coord_t'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam coord_t V_SYNC_LO = coord_t'(V_DISPLAY + V_FRONT);
  localparam coord_t V_SYNC_HI = coord_t'(V_DISPLAY + V_FRONT + V_SYNC);

  logic tick;

  pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .p_tick (tick)
  );

  coord_t x_reg, x_next, y_reg, y_next;
  logic   video_reg, video_next;
  logic   hsync_reg, hsync_next;
  logic   vsync_reg, vsync_next;
  logic   frame_reg, frame_next;
  logic   x_wrap, y_wrap;

  assign x_wrap = (x_reg == H_LAST);
  assign y_wrap = (y_reg == V_LAST);

  // Decodes are taken from the next counter values so they land on the same
  // edge as the counters. They only update on tick edges, which keeps
  // video_on low from reset until the first pixel actually advances.
  always_comb begin
    x_next     = x_reg;
    y_next     = y_reg;
    video_next = video_reg;
    hsync_next = hsync_reg;
    vsync_next = vsync_reg;
    frame_next = 1'b0;
    if (tick) begin
      if (x_wrap) begin
        x_next = '0;
        y_next = y_wrap ? '0 : y_reg + coord_t'(1);
      end else begin
        x_next = x_reg + coord_t'(1);
      end
      frame_next = x_wrap && y_wrap;
      video_next = (x_next < H_VIS) && (y_next < V_VIS);
      hsync_next = sync_level(in_window(x_next, H_SYNC_LO, H_SYNC_HI), SYNC_POL);
      vsync_next = sync_level(in_window(y_next, V_SYNC_LO, V_SYNC_HI), SYNC_POL);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_reg     <= '0;
      y_reg     <= '0;
      video_reg <= 1'b0;
      hsync_reg <= ~SYNC_POL;
      vsync_reg <= ~SYNC_POL;
      frame_reg <= 1'b0;
    end else begin
      x_reg     <= x_next;
      y_reg     <= y_next;
      video_reg <= video_next;
      hsync_reg <= hsync_next;
      vsync_reg <= vsync_next;
      frame_reg <= frame_next;
    end
  end

  assign p_tick      = tick;
  assign pixel_x     = x_reg;
  assign pixel_y     = y_reg;
  assign video_on    = video_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign frame_start = frame_reg;

endmodule

// File: tb/tb_vga_sync.sv
// ---------------------------------------------------------------------------
// tb_vga_sync
// Instance a: default 640x480 timing, CLK_DIV=4, active-low sync.
// Instance b: shrunken 15x8 timing, CLK_DIV=1, active-high sync, so whole
// frames fit in a short run.
// ---------------------------------------------------------------------------
module tb_vga_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic       a_tick, a_video, a_hs, a_vs, a_frame;
  logic [9:0] a_x, a_y;
  logic       b_tick, b_video, b_hs, b_vs, b_frame;
  logic [9:0] b_x, b_y;

  vga_sync u_dut_a (
    .clk(clk), .rst(rst_a), .p_tick(a_tick), .pixel_x(a_x), .pixel_y(a_y),
    .video_on(a_video), .hsync(a_hs), .vsync(a_vs), .frame_start(a_frame)
  );

  // H: 8 visible, sync 10..12, total 15.  V: 4 visible, sync 5..6, total 8.
  vga_sync #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .CLK_DIV(1), .SYNC_POL(1'b1)
  ) u_dut_b (
    .clk(clk), .rst(rst_b), .p_tick(b_tick), .pixel_x(b_x), .pixel_y(b_y),
    .video_on(b_video), .hsync(b_hs), .vsync(b_vs), .frame_start(b_frame)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Wait for a pixel tick on instance a, then one more clk so the advanced
  // counters are visible.
  task automatic step_a();
    int n = 0;
    while (a_tick !== 1'b1 && n < 32) begin
      @(negedge clk);
      n++;
    end
    if (a_tick !== 1'b1) check_val("a_tick_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    int tk[$];
    int exp_x, exp_y;
    int pos_err, vid_err, fr_cnt, vs_low, hs_low, hs_fall, hs_rise, v_fall;
    int b_pos_err, b_vid_err, b_hs_err, b_vs_err, b_fr_err, b_tick_err;
    int b_hs_cnt, b_vs_cnt, b_fr_cnt, b_fr_first, b_fr_second;

    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (3) @(negedge clk);

    // ---- reset state ----
    check_val("a_rst_tick",  a_tick,  0);
    check_val("a_rst_x",     a_x,     0);
    check_val("a_rst_y",     a_y,     0);
    check_val("a_rst_video", a_video, 0);
    check_val("a_rst_hsync", a_hs,    1);
    check_val("a_rst_vsync", a_vs,    1);
    check_val("a_rst_frame", a_frame, 0);
    check_val("b_rst_hsync", b_hs,    0);
    check_val("b_rst_vsync", b_vs,    0);
    check_val("b_rst_video", b_video, 0);

    // ---- release a: tick period and first advance ----
    rst_a = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (a_tick === 1'b1) tk.push_back(k);
      if (k == 4) check_val("a_x_before_advance", a_x, 0);
      if (k == 5) begin
        check_val("a_first_x",     a_x,     1);
        check_val("a_first_y",     a_y,     0);
        check_val("a_first_video", a_video, 1);
        check_val("a_first_hsync", a_hs,    1);
        check_val("a_first_vsync", a_vs,    1);
      end
    end
    check_val("a_tick_count", tk.size(), 3);
    if (tk.size() == 3) begin
      check_val("a_first_tick_clk", tk[0], 4);
      check_val("a_tick_period_1", tk[1] - tk[0], 4);
      check_val("a_tick_period_2", tk[2] - tk[1], 4);
    end
    check_val("a_x_start", a_x, 2);

    // ---- one full line plus part of the next, ending at (300,1) ----
    exp_x = 2; exp_y = 0;
    pos_err = 0; vid_err = 0; fr_cnt = 0; vs_low = 0; hs_low = 0;
    hs_fall = -1; hs_rise = -1; v_fall = -1;
    for (int i = 0; i < 1098; i++) begin
      step_a();
      if (exp_x == 799) begin
        exp_x = 0;
        exp_y++;
      end else begin
        exp_x++;
      end
      if (a_x !== 10'(exp_x) || a_y !== 10'(exp_y)) pos_err++;
      if (a_video !== ((exp_x < 640) && (exp_y < 480))) vid_err++;
      if (a_frame === 1'b1) fr_cnt++;
      if (a_vs !== 1'b1) vs_low++;
      if (a_hs === 1'b0) begin
        hs_low++;
        if (hs_fall < 0) hs_fall = int'(a_x);
      end else if (hs_fall >= 0 && hs_rise < 0) begin
        hs_rise = int'(a_x);
      end
      if (a_video === 1'b0 && v_fall < 0) v_fall = int'(a_x);
      if (exp_x == 0) begin
        check_val("a_wrap_x", a_x, 0);
        check_val("a_wrap_y", a_y, 1);
      end
    end
    check_val("a_pos_mismatches",   pos_err, 0);
    check_val("a_video_mismatches", vid_err, 0);
    check_val("a_frame_in_line",    fr_cnt,  0);
    check_val("a_vsync_low_ticks",  vs_low,  0);
    check_val("a_hsync_low_ticks",  hs_low,  96);
    check_val("a_hsync_fall_x",     hs_fall, 656);
    check_val("a_hsync_rise_x",     hs_rise, 752);
    check_val("a_video_fall_x",     v_fall,  640);
    check_val("a_mid_x",            a_x,     300);
    check_val("a_mid_y",            a_y,     1);

    // ---- asynchronous reset between clock edges ----
    #2 rst_a = 1'b0;
    #1;
    check_val("a_async_x",     a_x,     0);
    check_val("a_async_y",     a_y,     0);
    check_val("a_async_video", a_video, 0);
    check_val("a_async_hsync", a_hs,    1);
    check_val("a_async_vsync", a_vs,    1);
    check_val("a_async_tick",  a_tick,  0);
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
    step_a();
    check_val("a_restart_x",     a_x,     1);
    check_val("a_restart_y",     a_y,     0);
    check_val("a_restart_video", a_video, 1);

    // ---- instance b: CLK_DIV=1, active-high sync, full frames ----
    rst_b = 1'b1;
    @(negedge clk);
    check_val("b_first_tick", b_tick, 1);
    check_val("b_first_x",    b_x,    0);
    b_pos_err = 0; b_vid_err = 0; b_hs_err = 0; b_vs_err = 0; b_fr_err = 0; b_tick_err = 0;
    b_hs_cnt = 0; b_vs_cnt = 0; b_fr_cnt = 0; b_fr_first = -1; b_fr_second = -1;
    for (int n = 1; n <= 250; n++) begin
      int ex, ey;
      @(negedge clk);
      ex = n % 15;
      ey = (n / 15) % 8;
      if (b_tick !== 1'b1) b_tick_err++;
      if (b_x !== 10'(ex) || b_y !== 10'(ey)) b_pos_err++;
      if (b_video !== ((ex < 8) && (ey < 4))) b_vid_err++;
      if (b_hs !== ((ex >= 10) && (ex <= 12))) b_hs_err++;
      if (b_vs !== ((ey >= 5) && (ey <= 6))) b_vs_err++;
      if (b_frame !== (n % 120 == 0)) b_fr_err++;
      if (n >= 120 && n < 240) begin
        if (b_hs === 1'b1) b_hs_cnt++;
        if (b_vs === 1'b1) b_vs_cnt++;
      end
      if (b_frame === 1'b1) begin
        b_fr_cnt++;
        if (b_fr_first < 0) b_fr_first = n;
        else if (b_fr_second < 0) b_fr_second = n;
      end
    end
    check_val("b_tick_mismatches",  b_tick_err, 0);
    check_val("b_pos_mismatches",   b_pos_err,  0);
    check_val("b_video_mismatches", b_vid_err,  0);
    check_val("b_hsync_mismatches", b_hs_err,   0);
    check_val("b_vsync_mismatches", b_vs_err,   0);
    check_val("b_frame_mismatches", b_fr_err,   0);
    check_val("b_hsync_high_ticks", b_hs_cnt,   24);
    check_val("b_vsync_high_ticks", b_vs_cnt,   30);
    check_val("b_frame_pulses",     b_fr_cnt,   2);
    check_val("b_frame_first",      b_fr_first, 120);
    check_val("b_frame_length",     b_fr_second - b_fr_first, 120);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
